// File: rtl/rr_selector_if.sv
// rr_selector_if: request/response bundle for rr_selector.
//   req       : per-channel request (polarity set by the selector's ACT)
//   in        : per-channel data element
//   ack       : one-hot grant strobe, combinational
//   out_valid : output register holds valid data
//   out_ready : downstream accept
//   out       : registered selected element
//   out_pos   : registered one-hot index of the granted channel
//   out_idx   : registered binary index of the granted channel
// Modports: slave = selector side, master = requester/consumer side.

`ifndef HIGH
`define HIGH 1'b1
`endif
`ifndef LOW
`define LOW 1'b0
`endif

interface rr_selector_if #(
  parameter int unsigned DATA    = 8,
  parameter int unsigned IN      = 4,
  parameter int unsigned LOG2_IN = $clog2(IN)
);
  logic [IN-1:0]            req;
  logic [IN-1:0][DATA-1:0]  in;
  logic [IN-1:0]            ack;
  logic                     out_valid;
  logic                     out_ready;
  logic [DATA-1:0]          out;
  logic [IN-1:0]            out_pos;
  logic [LOG2_IN-1:0]       out_idx;

  modport slave (
    input  req, in, out_ready,
    output ack, out_valid, out, out_pos, out_idx
  );

  modport master (
    output req, in, out_ready,
    input  ack, out_valid, out, out_pos, out_idx
  );
endinterface

// File: rtl/rr_selector.sv
// rr_selector: grants one active request channel per cycle and registers the
// granted element together with its one-hot and binary index.
// Ports:
//   clk   : single clock, rising edge
//   reset : asynchronous, active-high
//   bus   : rr_selector_if.slave (req, in, ack, out_valid, out_ready,
//           out, out_pos, out_idx)
// Configuration macro RR_SELECTOR_FAIR_EN:
//   defined   -> round-robin arbitration starting at a rotating pointer
//   undefined -> fixed priority, lowest active index wins, no pointer

`ifndef HIGH
`define HIGH 1'b1
`endif
`ifndef LOW
`define LOW 1'b0
`endif

module rr_selector #(
  parameter int unsigned DATA    = 8,
  parameter int unsigned IN      = 4,
  parameter bit          ACT     = `HIGH,
  parameter int unsigned LOG2_IN = $clog2(IN)
) (
  input logic          clk,
  input logic          reset,
  rr_selector_if.slave bus
);

  logic [IN-1:0]      req_act;
  logic               any_req;
  logic               load;
  logic [LOG2_IN-1:0] lo_idx;
  logic [LOG2_IN-1:0] grant_idx;
  logic [IN-1:0]      grant_onehot;
  logic [DATA-1:0]    sel_data;

  // Normalise request polarity to active-high
  assign req_act = ACT ? bus.req : ~bus.req;
  assign any_req = |req_act;

  // Output register free or being drained this cycle
  assign load = (!bus.out_valid || bus.out_ready) && any_req;

`ifdef RR_SELECTOR_FAIR_EN
  logic [LOG2_IN-1:0] ptr;
  logic               hi_found;
  logic [LOG2_IN-1:0] hi_idx;

  // Round-robin: lowest active index at or above ptr, else lowest overall
  always_comb begin
    hi_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = IN - 1; i >= 0; i--) begin
      if (req_act[i]) begin
        lo_idx = LOG2_IN'(i);
        if (LOG2_IN'(i) >= ptr) begin
          hi_found = 1'b1;
          hi_idx   = LOG2_IN'(i);
        end
      end
    end
    grant_idx = hi_found ? hi_idx : lo_idx;
  end

  // Pointer moves past the winner; explicit wrap keeps it below IN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr <= '0;
    end else if (load) begin
      ptr <= (grant_idx == LOG2_IN'(IN - 1)) ? '0 : grant_idx + LOG2_IN'(1);
    end
  end
`else
  // Fixed priority: lowest active index wins
  always_comb begin
    lo_idx = '0;
    for (int i = IN - 1; i >= 0; i--) begin
      if (req_act[i]) begin
        lo_idx = LOG2_IN'(i);
      end
    end
    grant_idx = lo_idx;
  end
`endif

  assign grant_onehot = IN'(1) << grant_idx;
  assign sel_data     = bus.in[grant_idx];

  // Grant strobe only in a loading cycle and never during reset
  assign bus.ack = (load && !reset) ? grant_onehot : '0;

  // Output register; data fields keep their last value when draining
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.out_valid <= 1'b0;
      bus.out       <= '0;
      bus.out_pos   <= '0;
      bus.out_idx   <= '0;
    end else if (load) begin
      bus.out_valid <= 1'b1;
      bus.out       <= sel_data;
      bus.out_pos   <= grant_onehot;
      bus.out_idx   <= grant_idx;
    end else if (bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rr_selector.sv
// tb_rr_selector: randomized and directed bench for rr_selector with a
// behavioural reference model (modulo scan over channels).
`ifndef HIGH
`define HIGH 1'b1
`endif
`ifndef LOW
`define LOW 1'b0
`endif

module tb_rr_selector;
  localparam int unsigned DATA = 8;
  localparam int unsigned IN   = 4;
  localparam int unsigned LG   = 2;
  localparam int unsigned IN3  = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  rr_selector_if #(.DATA(DATA), .IN(IN),  .LOG2_IN(LG)) if4();
  rr_selector_if #(.DATA(DATA), .IN(IN3), .LOG2_IN(LG)) if3();
  rr_selector_if #(.DATA(DATA), .IN(IN),  .LOG2_IN(LG)) ifl();

  rr_selector #(.DATA(DATA), .IN(IN),  .ACT(`HIGH), .LOG2_IN(LG)) u4 (.clk(clk), .reset(reset), .bus(if4.slave));
  rr_selector #(.DATA(DATA), .IN(IN3), .ACT(`HIGH), .LOG2_IN(LG)) u3 (.clk(clk), .reset(reset), .bus(if3.slave));
  rr_selector #(.DATA(DATA), .IN(IN),  .ACT(`LOW),  .LOG2_IN(LG)) ul (.clk(clk), .reset(reset), .bus(ifl.slave));

  int vectors = 0;
  int miscompares = 0;

  // Reference model state for u4
  logic            m_valid;
  logic [DATA-1:0] m_out;
  logic [IN-1:0]   m_pos;
  int              m_idx;
  int              m_ptr;
  logic [IN-1:0]   exp_ack;
  logic [IN-1:0]   obs_ack;

  // First active channel scanning p, p+1, ... modulo n
  function automatic int pick(input logic [IN-1:0] r, input int n, input int p);
    logic [IN-1:0] t;
    for (int k = 0; k < n; k++) begin
      t = r >> ((p + k) % n);
      if (t[0]) return (p + k) % n;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_valid = 1'b0; m_out = '0; m_pos = '0; m_idx = 0; m_ptr = 0;
  endtask

  // One clock of u4 with the model advanced alongside
  task automatic tick();
    logic [IN*DATA-1:0] flat;
    logic               ld;
    int                 g;
    #1;
    ld      = (!m_valid || if4.out_ready) && (if4.req != '0);
    g       = ld ? pick(if4.req, IN, m_ptr) : 0;
    exp_ack = ld ? (4'b0001 << g) : 4'b0000;
    obs_ack = if4.ack;
    flat    = if4.in;
    flat    = flat >> (g * DATA);
    @(posedge clk);
    if (ld) begin
      m_valid = 1'b1;
      m_out   = flat[DATA-1:0];
      m_idx   = g;
      m_pos   = exp_ack;
`ifdef RR_SELECTOR_FAIR_EN
      m_ptr   = (g + 1) % IN;
`endif
    end else if (if4.out_ready) begin
      m_valid = 1'b0;
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    if4.req = 4'b1111; if4.out_ready = 1'b1; if4.in = 32'hA3A2A1A0;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (if4.out_valid !== 1'b0 || if4.out !== 8'h00 || if4.out_pos !== 4'h0 || if4.out_idx !== 2'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: got v=%0b out=%0h pos=%0h idx=%0d required all zero",
               if4.out_valid, if4.out, if4.out_pos, if4.out_idx);
    end
    vectors++;
    if (if4.ack !== 4'h0) begin
      miscompares++;
      $display("FAIL reset_ack: got %0h required 0", if4.ack);
    end
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_sweep();
    int seq[5];
`ifdef RR_SELECTOR_FAIR_EN
    seq = '{0, 1, 2, 3, 0};
`else
    seq = '{0, 0, 0, 0, 0};
`endif
    if4.req = 4'b1111; if4.out_ready = 1'b1; if4.in = 32'hA3A2A1A0;
    for (int k = 0; k < 5; k++) begin
      tick();
      vectors++;
      if (obs_ack !== exp_ack) begin
        miscompares++;
        $display("FAIL sweep_ack[%0d]: got %0h required %0h", k, obs_ack, exp_ack);
      end
      vectors++;
      if (int'(if4.out_idx) != seq[k] || if4.out !== 8'(8'hA0 + seq[k]) || if4.out_valid !== 1'b1) begin
        miscompares++;
        $display("FAIL sweep_out[%0d]: got idx=%0d out=%0h v=%0b required idx=%0d out=%0h v=1",
                 k, if4.out_idx, if4.out, if4.out_valid, seq[k], 8'(8'hA0 + seq[k]));
      end
    end
  endtask

  task automatic test_stall();
    int after;
`ifdef RR_SELECTOR_FAIR_EN
    after = 3;
`else
    after = 1;
`endif
    // Drain with nothing pending: valid clears, data kept
    if4.req = 4'b0000; if4.out_ready = 1'b1;
    tick();
    vectors++;
    if (if4.out_valid !== 1'b0 || if4.out !== m_out || int'(if4.out_idx) != m_idx) begin
      miscompares++;
      $display("FAIL drain_idle: got v=%0b out=%0h idx=%0d required v=0 out=%0h idx=%0d",
               if4.out_valid, if4.out, if4.out_idx, m_out, m_idx);
    end
    if4.req = 4'b1010; if4.out_ready = 1'b0; if4.in = 32'h44332211;
    tick();
    vectors++;
    if (if4.out_idx !== 2'd1 || if4.out !== 8'h22 || obs_ack !== 4'b0010) begin
      miscompares++;
      $display("FAIL stall_first: got idx=%0d out=%0h ack=%0h required idx=1 out=22 ack=2",
               if4.out_idx, if4.out, obs_ack);
    end
    for (int k = 0; k < 3; k++) begin
      if4.req = (k == 1) ? 4'b0000 : 4'b1010;
      if4.in  = $urandom;
      tick();
      vectors++;
      if (obs_ack !== 4'b0000 || if4.out_idx !== 2'd1 || if4.out !== 8'h22 || if4.out_valid !== 1'b1) begin
        miscompares++;
        $display("FAIL stall_hold[%0d]: got ack=%0h idx=%0d out=%0h v=%0b required ack=0 idx=1 out=22 v=1",
                 k, obs_ack, if4.out_idx, if4.out, if4.out_valid);
      end
    end
    if4.req = 4'b1010; if4.out_ready = 1'b1;
    tick();
    vectors++;
    if (int'(if4.out_idx) != after || obs_ack !== exp_ack) begin
      miscompares++;
      $display("FAIL stall_release: got idx=%0d ack=%0h required idx=%0d ack=%0h",
               if4.out_idx, obs_ack, after, exp_ack);
    end
  endtask

  task automatic test_back_to_back();
    if4.req = 4'b0110; if4.out_ready = 1'b1; if4.in = 32'h0D0C0B0A;
    for (int k = 0; k < 4; k++) begin
      tick();
      vectors++;
      if (obs_ack !== exp_ack || int'(if4.out_idx) != m_idx || if4.out !== m_out || if4.out_valid !== 1'b1) begin
        miscompares++;
        $display("FAIL b2b[%0d]: got ack=%0h idx=%0d out=%0h required ack=%0h idx=%0d out=%0h",
                 k, obs_ack, if4.out_idx, if4.out, exp_ack, m_idx, m_out);
      end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 300; k++) begin
      if4.req       = 4'($urandom);
      if4.in        = $urandom;
      if4.out_ready = ($urandom_range(0, 3) != 0);
      tick();
      vectors++;
      if (obs_ack !== exp_ack || if4.out_valid !== m_valid || if4.out !== m_out ||
          int'(if4.out_idx) != m_idx || if4.out_pos !== m_pos) begin
        miscompares++;
        $display("FAIL random[%0d]: got ack=%0h v=%0b out=%0h idx=%0d pos=%0h required ack=%0h v=%0b out=%0h idx=%0d pos=%0h",
                 k, obs_ack, if4.out_valid, if4.out, if4.out_idx, if4.out_pos,
                 exp_ack, m_valid, m_out, m_idx, m_pos);
      end
    end
  endtask

  task automatic test_async_reset();
    if4.req = 4'b1111; if4.out_ready = 1'b0; if4.in = 32'h5A5A5A5A;
    tick();
    #2;
    reset = 1'b1;
    #1;
    vectors++;
    if (if4.out_valid !== 1'b0 || if4.out !== 8'h00 || if4.ack !== 4'h0) begin
      miscompares++;
      $display("FAIL async_reset: got v=%0b out=%0h ack=%0h required 0,0,0",
               if4.out_valid, if4.out, if4.ack);
    end
    @(posedge clk);
    #2;
    reset = 1'b0;
    model_reset();
    if4.req = 4'b1000; if4.out_ready = 1'b1;
    tick();
    vectors++;
    if (if4.out_idx !== 2'd3 || if4.out_valid !== 1'b1 || obs_ack !== 4'b1000) begin
      miscompares++;
      $display("FAIL post_reset_grant: got idx=%0d v=%0b ack=%0h required idx=3 v=1 ack=8",
               if4.out_idx, if4.out_valid, obs_ack);
    end
  endtask

  task automatic test_non_pow2();
    int seq[4];
    logic [2:0] a;
`ifdef RR_SELECTOR_FAIR_EN
    seq = '{1, 2, 0, 1};
`else
    seq = '{0, 0, 0, 0};
`endif
    if3.req = 3'b100; if3.out_ready = 1'b1; if3.in = {8'h32, 8'h31, 8'h30};
    #1;
    a = if3.ack;
    @(posedge clk); #1;
    vectors++;
    if (a !== 3'b100 || if3.out_idx !== 2'd2 || if3.out !== 8'h32) begin
      miscompares++;
      $display("FAIL in3_first: got ack=%0h idx=%0d out=%0h required ack=4 idx=2 out=32", a, if3.out_idx, if3.out);
    end
    if3.req = 3'b111;
    #1;
    a = if3.ack;
    @(posedge clk); #1;
    vectors++;
    if (a !== 3'b001 || if3.out_idx !== 2'd0 || if3.out !== 8'h30) begin
      miscompares++;
      $display("FAIL in3_wrap: got ack=%0h idx=%0d out=%0h required ack=1 idx=0 out=30", a, if3.out_idx, if3.out);
    end
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      vectors++;
      if (int'(if3.out_idx) != seq[k]) begin
        miscompares++;
        $display("FAIL in3_seq[%0d]: got idx=%0d required %0d", k, if3.out_idx, seq[k]);
      end
    end
    if3.req = 3'b000;
  endtask

  task automatic test_active_low();
    logic [3:0] a;
    ifl.req = 4'b1110; ifl.out_ready = 1'b1; ifl.in = 32'hD3D2D1D0;
    #1;
    a = ifl.ack;
    @(posedge clk); #1;
    vectors++;
    if (a !== 4'b0001 || ifl.out_idx !== 2'd0 || ifl.out !== 8'hD0 || ifl.out_pos !== 4'b0001 || ifl.out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL act_low_grant: got ack=%0h idx=%0d out=%0h pos=%0h v=%0b required ack=1 idx=0 out=D0 pos=1 v=1",
               a, ifl.out_idx, ifl.out, ifl.out_pos, ifl.out_valid);
    end
    ifl.req = 4'b1111;
    #1;
    a = ifl.ack;
    @(posedge clk); #1;
    vectors++;
    if (a !== 4'b0000 || ifl.out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL act_low_idle: got ack=%0h v=%0b required ack=0 v=0", a, ifl.out_valid);
    end
  endtask

  initial begin
    if3.req = '0; if3.in = '0; if3.out_ready = 1'b1;
    ifl.req = 4'b1111; ifl.in = '0; ifl.out_ready = 1'b1;
    test_reset();
    test_sweep();
    test_stall();
    test_back_to_back();
    test_random();
    test_async_reset();
    test_non_pow2();
    test_active_low();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rr_selector.md
RR_SELECTOR -- requirements
Module: rr_selector

Interface
REQ-001 Parameter DATA, default 8: width of one element in bits.
REQ-002 Parameter IN, default 4: number of request channels, IN >= 2.
REQ-003 Parameter ACT, default `HIGH: polarity of req; all other control ports are active-high.
REQ-004 Parameter LOG2_IN, default $clog2(IN): width of out_idx.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 req  input  IN  per-channel request, polarity per ACT.
REQ-008 in  input  IN x DATA  per-channel data, sampled only when granted.
REQ-009 ack  output  IN  one-hot, combinational; ack[i]=1 in the cycle channel i's data is captured.
REQ-010 out_valid  output  1  output register holds valid data.
REQ-011 out_ready  input  1  downstream accepts when out_valid && out_ready.
REQ-012 out  output  DATA  registered selected element.
REQ-013 out_pos  output  IN  registered one-hot index of the granted channel.
REQ-014 out_idx  output  LOG2_IN  registered binary index of the granted channel.

Function
REQ-015 The block SHALL have a load condition: load = (!out_valid || out_ready) && (any req active).
REQ-016 When load=1, the block SHALL grant exactly one active channel g, assert ack[g] in that cycle, and on the next edge set out=in[g], out_pos=onehot(g), out_idx=g, out_valid=1.
REQ-017 Latency SHALL be one cycle, req to out_valid; full throughput SHALL be one grant per cycle while out_ready=1.
REQ-018 When out_valid=1 and out_ready=0, the block SHALL hold out, out_pos, out_idx and ack=0, and SHALL leave the pointer unchanged.
REQ-019 When out_valid && out_ready and no req is active, out_valid SHALL clear on the next edge; out, out_pos and out_idx SHALL keep their last values.
REQ-020 Simultaneous handoff SHALL be supported: consume and new load in the same cycle keep out_valid=1 with the new data.
REQ-021 Round-robin (RR_SELECTOR_FAIR_EN defined): the search SHALL start at pointer p and scan p, p+1, ..., IN-1, 0, ..., p-1; the first active channel wins.
REQ-022 After each grant to channel g, the pointer SHALL become (g+1) mod IN; wrap from IN-1 to 0.
REQ-023 IN not a power of two: the pointer SHALL never take a value >= IN.
REQ-024 ack SHALL be all-zero whenever load=0.
REQ-025 A req deasserting while out is stalled SHALL NOT affect the registered outputs.

Reset
REQ-026 While reset=1, and independent of clk, the block SHALL hold out_valid=0, out=0, out_pos=0, out_idx=0 and pointer=0.
REQ-027 ack SHALL be 0 while reset=1.
REQ-028 Reset mid-transfer SHALL discard held data; the first grant after reset release SHALL follow pointer=0 rules.

Configuration
REQ-029 Macro RR_SELECTOR_FAIR_EN defined: round-robin arbitration per REQ-021..REQ-023.
REQ-030 Macro RR_SELECTOR_FAIR_EN undefined: fixed priority, lowest active index wins; the pointer register SHALL NOT be implemented.
REQ-031 All other behaviour, including ports, latency and reset values, SHALL be identical with and without RR_SELECTOR_FAIR_EN.

Verification
REQ-032 IN=4, DATA=8, FAIR_EN: req=4'b1111 held, out_ready=1, in[i]=8'hA0+i -> out_idx sequence 0,1,2,3,0; out=A0,A1,A2,A3,A0; one ack per cycle.
REQ-033 FAIR_EN: req=4'b1010, out_ready=0 for 3 cycles after the first grant -> out_idx=1 and ack=0 held for 3 cycles; then out_ready=1 -> next out_idx=3.
REQ-034 FAIR_EN undefined: req=4'b0110 held, out_ready=1 -> out_idx=1 every cycle, ack=4'b0010 every cycle.
REQ-035 IN=3, FAIR_EN: only req[2] active, then req=3'b111 -> out_idx 2, then 0 (wrap), never 3.
REQ-036 Reset asserted asynchronously between clock edges while out_valid=1 -> out_valid=0 and out=0 immediately; after release req=4'b1000 -> out_idx=3 one cycle later.
REQ-037 ACT=`LOW: req=4'b1110 -> channel 0 granted, ack=4'b0001.
